// File: rtl/pcie_flr_req_gen_if.sv
// Event handshake and completion report between the PCIe core and pcie_flr_req_gen.
// master = PCIe core side, slave = pcie_flr_req_gen.
interface pcie_flr_req_gen_if;
   logic        evt_valid;
   logic        evt_ready;
   logic [2:0]  evt_pf;
   logic [10:0] evt_vf;
   logic        evt_vf_active;
   logic        done_valid;
   logic [2:0]  done_pf;
   logic [10:0] done_vf;
   logic        done_vf_active;
   logic        done_timeout;

   modport master (
      output evt_valid, evt_pf, evt_vf, evt_vf_active,
      input  evt_ready, done_valid, done_pf, done_vf, done_vf_active, done_timeout
   );

   modport slave (
      input  evt_valid, evt_pf, evt_vf, evt_vf_active,
      output evt_ready, done_valid, done_pf, done_vf, done_vf_active, done_timeout
   );
endinterface

// File: rtl/pcie_flr_req_gen.sv
// pcie_flr_req_gen: turns FLR events into flr_req beats and tracks each function until its flr_rsp returns.
// Define PCIE_FLR_TIMEOUT_EN to add per-slot timeout counters and done_timeout reporting.
package pcie_ss_axis_pkg;
   typedef struct packed {
      logic [2:0]  pf;
      logic [10:0] vf;
      logic        vf_active;
   } t_flr_tdata;

   typedef struct packed {
      logic       tvalid;
      t_flr_tdata tdata;
   } t_axis_pcie_flr;
endpackage

module pcie_flr_req_gen
   import pcie_ss_axis_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned TIMEOUT_W       = 16,
   parameter int unsigned TIMEOUT_CYCLES  = 16'hFFFF
) (
   input  logic              clk,
   input  logic              rst,
   pcie_flr_req_gen_if.slave ctl,
   output t_axis_pcie_flr    flr_req,
   input  t_axis_pcie_flr    flr_rsp,
   output logic [3:0]        outstanding,
   output logic              err_unexp_rsp
);
   localparam int unsigned IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 8) begin : g_chk_slots
      $error("MAX_OUTSTANDING must be in 1..8");
   end
   if (longint'(TIMEOUT_CYCLES) >= (longint'(1) << TIMEOUT_W)) begin : g_chk_timeout
      $error("TIMEOUT_CYCLES must be less than 2**TIMEOUT_W");
   end

   logic [MAX_OUTSTANDING-1:0] valid_q, valid_d;
   t_flr_tdata                 key_q [MAX_OUTSTANDING];
   t_flr_tdata                 key_d [MAX_OUTSTANDING];
`ifdef PCIE_FLR_TIMEOUT_EN
   logic [MAX_OUTSTANDING-1:0] expired_q, expired_d;
   logic [TIMEOUT_W-1:0]       timer_q [MAX_OUTSTANDING];
   logic [TIMEOUT_W-1:0]       timer_d [MAX_OUTSTANDING];
   logic                       exp_any;
   logic [IW-1:0]              exp_idx;
`endif
   t_axis_pcie_flr req_q, req_d;
   logic           done_valid_q, done_valid_d;
   logic           done_to_q, done_to_d;
   t_flr_tdata     done_key_q, done_key_d;
   logic           err_q, err_d;

   logic          hit, free_any, dup, evt_rdy;
   logic [IW-1:0] hit_idx, free_idx;
   t_flr_tdata    rsp_key, evt_key;
   logic [3:0]    cnt;

   always_comb begin
      valid_d      = valid_q;
      key_d        = key_q;
      req_d        = '0;
      done_valid_d = 1'b0;
      done_to_d    = 1'b0;
      done_key_d   = '0;
      err_d        = err_q;

      // Keys are normalised so a PF reset never differs only by a stale vf field.
      rsp_key = flr_rsp.tdata;
      if (!rsp_key.vf_active) rsp_key.vf = '0;
      evt_key.pf        = ctl.evt_pf;
      evt_key.vf        = ctl.evt_vf_active ? ctl.evt_vf : 11'd0;
      evt_key.vf_active = ctl.evt_vf_active;

      hit = 1'b0; hit_idx = '0; free_any = 1'b0; free_idx = '0; dup = 1'b0; cnt = '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
         cnt = cnt + 4'(valid_q[i]);
         if (valid_q[i] && key_q[i] == rsp_key && !hit) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
         end
         if (!valid_q[i] && !free_any) begin
            free_any = 1'b1;
            free_idx = IW'(i);
         end
         if (valid_q[i] && key_q[i] == evt_key) dup = 1'b1;
      end
      evt_rdy = !rst && free_any;

`ifdef PCIE_FLR_TIMEOUT_EN
      expired_d = expired_q;
      timer_d   = timer_q;
      exp_any   = 1'b0;
      exp_idx   = '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
         if (valid_q[i] && !expired_q[i]) begin
            timer_d[i] = timer_q[i] + TIMEOUT_W'(1);
            if (timer_q[i] == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) expired_d[i] = 1'b1;
         end
         if (valid_q[i] && expired_q[i] && !exp_any) begin
            exp_any = 1'b1;
            exp_idx = IW'(i);
         end
      end
`endif

      if (flr_rsp.tvalid && hit) begin
         done_valid_d     = 1'b1;
         done_key_d       = key_q[hit_idx];
         valid_d[hit_idx] = 1'b0;
`ifdef PCIE_FLR_TIMEOUT_EN
         expired_d[hit_idx] = 1'b0;
      end else if (exp_any) begin
         done_valid_d       = 1'b1;
         done_to_d          = 1'b1;
         done_key_d         = key_q[exp_idx];
         valid_d[exp_idx]   = 1'b0;
         expired_d[exp_idx] = 1'b0;
`endif
      end
      if (flr_rsp.tvalid && !hit) err_d = 1'b1;

      // Allocation uses registered occupancy, so a slot freed this cycle is not reused until next.
      if (ctl.evt_valid && evt_rdy && !dup) begin
         valid_d[free_idx] = 1'b1;
         key_d[free_idx]   = evt_key;
`ifdef PCIE_FLR_TIMEOUT_EN
         timer_d[free_idx]   = '0;
         expired_d[free_idx] = 1'b0;
`endif
         req_d.tvalid = 1'b1;
         req_d.tdata  = evt_key;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q      <= '0;
         req_q        <= '0;
         done_valid_q <= 1'b0;
         done_to_q    <= 1'b0;
         done_key_q   <= '0;
         err_q        <= 1'b0;
         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            key_q[i] <= '0;
`ifdef PCIE_FLR_TIMEOUT_EN
            timer_q[i] <= '0;
`endif
         end
`ifdef PCIE_FLR_TIMEOUT_EN
         expired_q <= '0;
`endif
      end else begin
         valid_q      <= valid_d;
         key_q        <= key_d;
         req_q        <= req_d;
         done_valid_q <= done_valid_d;
         done_to_q    <= done_to_d;
         done_key_q   <= done_key_d;
         err_q        <= err_d;
`ifdef PCIE_FLR_TIMEOUT_EN
         timer_q   <= timer_d;
         expired_q <= expired_d;
`endif
      end
   end

   assign ctl.evt_ready      = evt_rdy;
   assign ctl.done_valid     = done_valid_q;
   assign ctl.done_timeout   = done_to_q;
   assign ctl.done_pf        = done_key_q.pf;
   assign ctl.done_vf        = done_key_q.vf;
   assign ctl.done_vf_active = done_key_q.vf_active;
   assign flr_req            = req_q;
   assign outstanding        = cnt;
   assign err_unexp_rsp      = err_q;
endmodule

// File: tb/tb_pcie_flr_req_gen.sv
// Bench for pcie_flr_req_gen: slot-table model with issue-cycle stamps plus directed scenarios.
// Timeout scenarios run only when PCIE_FLR_TIMEOUT_EN is defined.
module tb_pcie_flr_req_gen;
   import pcie_ss_axis_pkg::*;

   localparam int N  = 4;
   localparam int TC = 20;
`ifdef PCIE_FLR_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   t_axis_pcie_flr flr_req;
   t_axis_pcie_flr flr_rsp;
   logic [3:0]     outstanding;
   logic           err_unexp_rsp;

   pcie_flr_req_gen_if ctl();

   pcie_flr_req_gen #(.MAX_OUTSTANDING(N), .TIMEOUT_W(16), .TIMEOUT_CYCLES(TC)) dut (
      .clk(clk), .rst(rst), .ctl(ctl), .flr_req(flr_req), .flr_rsp(flr_rsp),
      .outstanding(outstanding), .err_unexp_rsp(err_unexp_rsp)
   );

   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic t_flr_tdata norm(input t_flr_tdata k);
      t_flr_tdata r = k;
      if (!r.vf_active) r.vf = '0;
      return r;
   endfunction

   // Model: each occupied slot remembers its key and the cycle its request was issued.
   bit             m_used [N];
   t_flr_tdata     m_key  [N];
   int             m_issue[N];
   bit             pre_used[N];
   int             m_cyc = 0;
   bit             started = 1'b0;
   t_axis_pcie_flr m_req;
   bit             m_dv, m_dto, m_err;
   t_flr_tdata     m_dkey;
   int             m_out;
   int             m_hit, m_exp, m_free;
   bit             m_dup;
   t_flr_tdata     m_rk, m_ek;

   always @(posedge clk) begin
      m_req = '0; m_dv = 1'b0; m_dto = 1'b0; m_dkey = '0;
      if (rst) begin
         for (int i = 0; i < N; i++) m_used[i] = 1'b0;
         m_err = 1'b0;
      end else begin
         for (int i = 0; i < N; i++) pre_used[i] = m_used[i];
         m_hit = -1; m_exp = -1; m_free = -1; m_dup = 1'b0;
         m_rk = norm(flr_rsp.tdata);
         if (flr_rsp.tvalid) begin
            for (int i = 0; i < N; i++)
               if (m_hit < 0 && pre_used[i] && m_key[i] == m_rk) m_hit = i;
            if (m_hit < 0) m_err = 1'b1;
         end
         for (int i = 0; i < N; i++)
            if (m_exp < 0 && TO_EN && pre_used[i] && (m_cyc - m_issue[i]) >= TC) m_exp = i;
         if (m_hit >= 0) begin
            m_dv = 1'b1; m_dkey = m_key[m_hit]; m_used[m_hit] = 1'b0;
         end else if (m_exp >= 0) begin
            m_dv = 1'b1; m_dto = 1'b1; m_dkey = m_key[m_exp]; m_used[m_exp] = 1'b0;
         end
         for (int i = 0; i < N; i++) if (m_free < 0 && !pre_used[i]) m_free = i;
         if (ctl.evt_valid && m_free >= 0) begin
            m_ek = '{pf: ctl.evt_pf, vf: ctl.evt_vf, vf_active: ctl.evt_vf_active};
            m_ek = norm(m_ek);
            for (int i = 0; i < N; i++) if (pre_used[i] && m_key[i] == m_ek) m_dup = 1'b1;
            if (!m_dup) begin
               m_used[m_free]  = 1'b1;
               m_key[m_free]   = m_ek;
               m_issue[m_free] = m_cyc + 1;
               m_req.tvalid    = 1'b1;
               m_req.tdata     = m_ek;
            end
         end
      end
      m_out = 0;
      for (int i = 0; i < N; i++) m_out += int'(m_used[i]);
      m_cyc++;
      started = 1'b1;
   end

   int req_cnt  = 0;
   int done_cnt = 0;

   always @(negedge clk) begin
      #1;
      if (started) begin
         chk("cmp_req", 32'(flr_req), 32'(m_req));
         chk("cmp_done",
             {15'd0, ctl.done_valid, ctl.done_timeout, ctl.done_vf_active, ctl.done_pf, ctl.done_vf},
             {15'd0, m_dv, m_dto, m_dkey.vf_active, m_dkey.pf, m_dkey.vf});
         chk("cmp_outstanding", 32'(outstanding), 32'(m_out));
         chk("cmp_err", 32'(err_unexp_rsp), 32'(m_err));
         chk("cmp_ready", 32'(ctl.evt_ready), 32'(!rst && m_out < N));
         if (flr_req.tvalid === 1'b1) req_cnt++;
         if (ctl.done_valid === 1'b1) done_cnt++;
      end
   end

   task automatic send_evt(input logic [2:0] pf, input logic [10:0] vf, input logic va);
      ctl.evt_valid = 1'b1; ctl.evt_pf = pf; ctl.evt_vf = vf; ctl.evt_vf_active = va;
      for (int n = 0; n < 100; n++) begin
         #1;
         if (ctl.evt_ready) begin
            @(negedge clk);
            ctl.evt_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      tests++; failed++;
      $display("FAIL evt_accept_bound: got no evt_ready, expected accept within 100 cycles");
      ctl.evt_valid = 1'b0;
   endtask

   task automatic send_rsp(input logic [2:0] pf, input logic [10:0] vf, input logic va);
      flr_rsp.tvalid = 1'b1; flr_rsp.tdata.pf = pf; flr_rsp.tdata.vf = vf; flr_rsp.tdata.vf_active = va;
      @(negedge clk);
      flr_rsp = '0;
   endtask

   int r0, d0;

   initial begin
      ctl.evt_valid = 1'b0; ctl.evt_pf = '0; ctl.evt_vf = '0; ctl.evt_vf_active = 1'b0;
      flr_rsp = '0;
      repeat (3) @(negedge clk);
      #2;
      chk("rst_out", 32'(outstanding), 0);
      chk("rst_req", 32'(flr_req), 0);
      chk("rst_ready", 32'(ctl.evt_ready), 0);
      @(negedge clk);
      rst = 1'b0;

      // PF2 request and echo
      send_evt(3'd2, 11'd0, 1'b0);
      #2;
      chk("t1_req_valid", 32'(flr_req.tvalid), 1);
      chk("t1_req_pf", 32'(flr_req.tdata.pf), 2);
      chk("t1_req_vf", 32'(flr_req.tdata.vf), 0);
      chk("t1_out", 32'(outstanding), 1);
      @(negedge clk);
      send_rsp(3'd2, 11'd0, 1'b0);
      #2;
      chk("t1_done", 32'(ctl.done_valid), 1);
      chk("t1_done_pf", 32'(ctl.done_pf), 2);
      chk("t1_done_to", 32'(ctl.done_timeout), 0);
      chk("t1_out0", 32'(outstanding), 0);
      @(negedge clk);

      // Fill table with PF0 VF0..3, fifth event waits for a freed slot
      for (int v = 0; v < 4; v++) send_evt(3'd0, 11'(v), 1'b1);
      ctl.evt_valid = 1'b1; ctl.evt_pf = 3'd0; ctl.evt_vf = 11'd4; ctl.evt_vf_active = 1'b1;
      flr_rsp.tvalid = 1'b1; flr_rsp.tdata.pf = 3'd0; flr_rsp.tdata.vf = 11'd2; flr_rsp.tdata.vf_active = 1'b1;
      #2;
      chk("t2_full_ready", 32'(ctl.evt_ready), 0);
      chk("t2_full_out", 32'(outstanding), 4);
      @(negedge clk);
      flr_rsp = '0;
      #2;
      chk("t2_done_vf", 32'(ctl.done_vf), 2);
      chk("t2_ready_back", 32'(ctl.evt_ready), 1);
      chk("t2_no_req_yet", 32'(flr_req.tvalid), 0);
      @(negedge clk);
      ctl.evt_valid = 1'b0;
      #2;
      chk("t2_req5_valid", 32'(flr_req.tvalid), 1);
      chk("t2_req5_vf", 32'(flr_req.tdata.vf), 4);
      @(negedge clk);
      send_rsp(3'd0, 11'd0, 1'b1);
      send_rsp(3'd0, 11'd1, 1'b1);
      send_rsp(3'd0, 11'd3, 1'b1);
      send_rsp(3'd0, 11'd4, 1'b1);
      #2;
      chk("t2_drained", 32'(outstanding), 0);
      @(negedge clk);

      // Duplicate PF1/VF3 merges into the first slot
      r0 = req_cnt; d0 = done_cnt;
      send_evt(3'd1, 11'd3, 1'b1);
      send_evt(3'd1, 11'd3, 1'b1);
      repeat (2) @(negedge clk);
      send_rsp(3'd1, 11'd3, 1'b1);
      repeat (3) @(negedge clk);
      #2;
      chk("t3_req_count", 32'(req_cnt - r0), 1);
      chk("t3_done_count", 32'(done_cnt - d0), 1);
      @(negedge clk);

`ifdef PCIE_FLR_TIMEOUT_EN
      begin
         int  n;
         bit  found;
         send_evt(3'd3, 11'd0, 1'b0);
         n = 0; found = 1'b0;
         while (!found && n < 100) begin
            @(negedge clk);
            n++;
            #2;
            if (ctl.done_valid) found = 1'b1;
         end
         chk("t4_latency", 32'(n), 21);
         chk("t4_timeout", 32'(ctl.done_timeout), 1);
         chk("t4_pf", 32'(ctl.done_pf), 3);
         @(negedge clk);
         send_rsp(3'd3, 11'd0, 1'b0);
         #2;
         chk("t4_late_err", 32'(err_unexp_rsp), 1);
         @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;

         // Response on slot 0 collides with expiry of slot 1
         send_evt(3'd4, 11'd0, 1'b0);
         send_evt(3'd5, 11'd0, 1'b0);
         send_rsp(3'd4, 11'd0, 1'b0);
         send_evt(3'd6, 11'd0, 1'b0);
         repeat (18) @(negedge clk);
         send_rsp(3'd6, 11'd0, 1'b0);
         #2;
         chk("t5_first_pf", 32'(ctl.done_pf), 6);
         chk("t5_first_to", 32'(ctl.done_timeout), 0);
         @(negedge clk);
         #2;
         chk("t5_second_pf", 32'(ctl.done_pf), 5);
         chk("t5_second_to", 32'(ctl.done_timeout), 1);
         @(negedge clk);
      end
`endif

      // Reset with three outstanding
      send_evt(3'd1, 11'd0, 1'b0);
      send_evt(3'd1, 11'd1, 1'b1);
      send_evt(3'd2, 11'd5, 1'b1);
      #2;
      chk("t6_out3", 32'(outstanding), 3);
      @(negedge clk);
      rst = 1'b1;
      flr_rsp.tvalid = 1'b1; flr_rsp.tdata.pf = 3'd1; flr_rsp.tdata.vf = 11'd0; flr_rsp.tdata.vf_active = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      flr_rsp.tdata.pf = 3'd1; flr_rsp.tdata.vf = 11'd1; flr_rsp.tdata.vf_active = 1'b1;
      #2;
      chk("t6_out0", 32'(outstanding), 0);
      chk("t6_no_done", 32'(ctl.done_valid), 0);
      chk("t6_err_clear", 32'(err_unexp_rsp), 0);
      @(negedge clk);
      flr_rsp = '0;
      #2;
      chk("t6_err_set", 32'(err_unexp_rsp), 1);
      chk("t6_no_done2", 32'(ctl.done_valid), 0);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected completion before 200000");
      $fatal(1);
   end
endmodule

// File: doc/pcie_flr_req_gen.md
# pcie_flr_req_gen

Requester-side counterpart of the port FLR reset manager. It converts function-level-reset events from the PCIe subsystem into single-cycle `t_axis_pcie_flr` request beats and tracks each outstanding function until the matching FLR response beat returns. It reports completion, or optionally timeout, back to the PCIe subsystem. The block sits in the PCIe subsystem wrapper on the CSR clock domain and drives the `flr_req` / `flr_rsp` pair of one PCIe link.

## Interface
Parameters:
- `MAX_OUTSTANDING`, 4: tracking-table slots; range 1–8.
- `TIMEOUT_W`, 16: width of each per-slot timeout counter.
- `TIMEOUT_CYCLES`, 16'hFFFF: cycles from request issue to timeout; must be less than 2^`TIMEOUT_W`.

Ports:
- `clk`, in, 1: CSR clock. Single clock domain.
- `rst`, in, 1: synchronous, active-high reset.
- `evt_valid`, in, 1: FLR event from the PCIe core.
- `evt_ready`, out, 1: event accepted when `evt_valid && evt_ready`.
- `evt_pf`, in, 3: PF number of the event.
- `evt_vf`, in, 11: VF number of the event.
- `evt_vf_active`, in, 1: 1 means a VF reset; 0 means a PF reset, and `evt_vf` is ignored.
- `flr_req`, out, `pcie_ss_axis_pkg::t_axis_pcie_flr`: request beat (tvalid plus tdata pf/vf/vf_active). No backpressure.
- `flr_rsp`, in, `pcie_ss_axis_pkg::t_axis_pcie_flr`: response beat from the FLR reset manager.
- `done_valid`, out, 1: one-cycle completion pulse.
- `done_pf`, out, 3: PF of the completed function.
- `done_vf`, out, 11: VF of the completed function.
- `done_vf_active`, out, 1: VF flag of the completed function.
- `done_timeout`, out, 1: qualifies `done_valid`; 1 means the slot expired without a response.
- `outstanding`, out, 4: number of occupied slots.
- `err_unexp_rsp`, out, 1: sticky; set by a response that matches no slot; cleared only by `rst`.

## Operation
Function key:
- Key = {vf_active, pf, vf when vf_active, else 0}.
- Two keys match only when all three fields are equal.

Tracking table:
- `MAX_OUTSTANDING` slots.
- Each slot holds valid, key, timer and expired.

Event accept:
- `evt_ready` = !rst && (at least one free slot).
- Accepted event whose key matches an occupied slot: merged. No new request, no new slot; completion is reported once, for the original slot.
- Otherwise the event takes the lowest-index free slot, loads timer = 0, and registers a request beat.

Request issue:
- `flr_req.tvalid` is high for exactly one cycle per new slot.
- tdata carries the event key; the vf field is 0 when vf_active = 0.

Response match:
- `flr_rsp.tvalid` is compared against all valid slots.
- Hit: the slot is freed and a completion is queued with timeout = 0.
- Miss: `err_unexp_rsp` is set and the beat is dropped.

Timeout (with `PCIE_FLR_TIMEOUT_EN`):
- The timer increments each cycle while the slot is valid and not expired.
- At `TIMEOUT_CYCLES` the slot sets expired and the timer holds.
- An expired slot frees when its completion is issued, with timeout = 1.

Completion arbitration (one `done` per cycle):
- A response hit has priority.
- Otherwise, the lowest-index expired slot completes.
- Pending expired slots wait; none is lost.

Simultaneous events:
- Response and expiry on the same slot in the same cycle: the response wins, timeout = 0.
- Response freeing a slot and a new event in the same cycle: the freed slot is not reusable until the next cycle. `evt_ready` is computed from registered slot state.
- A late response for a slot already completed by timeout is unexpected and sets `err_unexp_rsp`.

Reset:
- `rst` mid-operation clears every slot with no completions issued.
- A `flr_rsp` arriving during or after reset for a pre-reset request sets `err_unexp_rsp` (after reset).

## Timing
- Reset values: `flr_req.tvalid` = 0, `flr_req.tdata` = 0, `evt_ready` = 0, `done_*` = 0, `outstanding` = 0, `err_unexp_rsp` = 0.
- `evt_ready` rises the first cycle after `rst` deasserts.
- Event accepted in cycle N → `flr_req.tvalid` in N+1; slot valid from N+1; `outstanding` updates in N+1.
- `flr_rsp.tvalid` in cycle M with a hit → `done_valid` in M+1; slot free in M+1; `evt_ready` reflects it in M+1.
- Timeout: the slot is issued at cycle T (timer = 0); expired is set at T+`TIMEOUT_CYCLES`; `done_valid` follows at the earliest 1 cycle later, subject to arbitration.
- A full table holds `evt_ready` low; the upstream must hold `evt_valid` and its fields stable.
- Back-to-back events are accepted one per cycle while slots remain.

## Configuration
- `PCIE_FLR_TIMEOUT_EN` defined: per-slot timers and expiry logic are present; `done_timeout` can assert.
- Undefined: no timers; slots wait indefinitely for a response; `done_timeout` is tied to 0; `TIMEOUT_*` parameters are ignored.

## Test plan
- Reset, then event PF2 (vf_active = 0) → `flr_req` 1 cycle later with pf = 2, vf = 0; response echo → `done_valid` 1 cycle later, pf = 2, `done_timeout` = 0, `outstanding` 1→0.
- 5 distinct VF events (PF0, VF0–4) with `MAX_OUTSTANDING` = 4 → 4 requests, `evt_ready` low on the 5th; respond to VF2 → 5th request issued 2 cycles after the response.
- Duplicate event PF1/VF3 while outstanding → no second `flr_req`; a single response → exactly one `done_valid`.
- `PCIE_FLR_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 20, no response → `done_valid` with `done_timeout` = 1 at issue + 21; a later response → `err_unexp_rsp` = 1.
- Response for slot 0 and expiry of slot 1 in the same cycle → slot-0 done in cycle +1, slot-1 timeout done in +2.
- `rst` asserted with 3 outstanding → no `done_valid`; `outstanding` = 0; a post-reset response sets `err_unexp_rsp`.
